// File: rtl/axi4_sram_responder.sv
// AXI4 slave backed by a 64-bit on-chip SRAM: one write burst and one read burst
// in flight at a time, each with its own engine, sharing a dual-port memory.
module axi4_sram_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int ID_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  // write address
  input  logic                  S_AXI_awvalid,
  output logic                  S_AXI_awready,
  input  logic [ID_WIDTH-1:0]   S_AXI_awid,
  input  logic [ADDR_WIDTH-1:0] S_AXI_awaddr,
  input  logic [7:0]            S_AXI_awlen,
  input  logic [2:0]            S_AXI_awsize,
  input  logic [1:0]            S_AXI_awburst,
  input  logic                  S_AXI_awlock,
  input  logic [3:0]            S_AXI_awcache,
  input  logic [2:0]            S_AXI_awprot,
  input  logic [3:0]            S_AXI_awqos,
  // write data
  input  logic                  S_AXI_wvalid,
  output logic                  S_AXI_wready,
  input  logic [63:0]           S_AXI_wdata,
  input  logic [7:0]            S_AXI_wstrb,
  input  logic                  S_AXI_wlast,
  // write response
  output logic                  S_AXI_bvalid,
  input  logic                  S_AXI_bready,
  output logic [ID_WIDTH-1:0]   S_AXI_bid,
  output logic [1:0]            S_AXI_bresp,
  // read address
  input  logic                  S_AXI_arvalid,
  output logic                  S_AXI_arready,
  input  logic [ID_WIDTH-1:0]   S_AXI_arid,
  input  logic [ADDR_WIDTH-1:0] S_AXI_araddr,
  input  logic [7:0]            S_AXI_arlen,
  input  logic [2:0]            S_AXI_arsize,
  input  logic [1:0]            S_AXI_arburst,
  input  logic                  S_AXI_arlock,
  input  logic [3:0]            S_AXI_arcache,
  input  logic [2:0]            S_AXI_arprot,
  input  logic [3:0]            S_AXI_arqos,
  // read data
  output logic                  S_AXI_rvalid,
  input  logic                  S_AXI_rready,
  output logic [ID_WIDTH-1:0]   S_AXI_rid,
  output logic [63:0]           S_AXI_rdata,
  output logic [1:0]            S_AXI_rresp,
  output logic                  S_AXI_rlast,
  // engine state for checkers
  output logic [1:0]            dbg_w_state,
  output logic [1:0]            dbg_r_state
);

  // Handshake: on every channel a transfer happens at the rising edge where
  // valid && ready; once valid is raised it stays high with a stable payload
  // until that edge.

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS) << 3;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [63:0] mem [DEPTH_WORDS];

  // A beat touches the SRAM only if it is in range and the burst type is supported.
  function automatic logic beat_ok(input logic [ADDR_WIDTH-1:0] addr,
                                   input logic [1:0]            burst);
    return ({1'b0, addr} < MEM_BYTES) && (burst == BURST_FIXED || burst == BURST_INCR);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [2:0]            size,
                                                       input logic [1:0]            burst);
    return (burst == BURST_FIXED) ? addr : addr + (ADDR_WIDTH'(1) << size);
  endfunction

  // ---------------- write engine ----------------
  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [8:0]            w_cnt;
  logic                  w_err;
  logic                  aw_hs, w_hs, b_hs, w_overrun, w_beat_ok;
  logic [IDX_W-1:0]      w_idx;

  assign aw_hs     = S_AXI_awvalid && S_AXI_awready;
  assign w_hs      = S_AXI_wvalid && S_AXI_wready;
  assign b_hs      = S_AXI_bvalid && S_AXI_bready;
  assign w_overrun = w_cnt > {1'b0, w_len};
  assign w_beat_ok = !w_overrun && beat_ok(w_addr, w_burst);
  assign w_idx     = w_addr[IDX_W+2:3];

  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && S_AXI_wlast) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_awready = 1'b0;
    S_AXI_wready  = 1'b0;
    S_AXI_bvalid  = 1'b0;
    S_AXI_bresp   = RESP_OKAY;
    case (w_state)
      W_IDLE: S_AXI_awready = !reset;
      W_DATA: S_AXI_wready  = 1'b1;
      W_RESP: begin
        S_AXI_bvalid = 1'b1;
        S_AXI_bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  assign S_AXI_bid   = w_id;
  assign dbg_w_state = w_state;

  // The beat counter saturates at 256 so runaway bursts keep flagging overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id    <= S_AXI_awid;
        w_addr  <= S_AXI_awaddr;
        w_len   <= S_AXI_awlen;
        w_size  <= S_AXI_awsize;
        w_burst <= S_AXI_awburst;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_size, w_burst);
        if (!w_cnt[8]) w_cnt <= w_cnt + 9'd1;
        if (!w_beat_ok || (S_AXI_wlast && (w_cnt < {1'b0, w_len}))) w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_hs && w_beat_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (S_AXI_wstrb[b]) mem[w_idx][b*8 +: 8] <= S_AXI_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t              r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_cnt;
  logic [63:0]           r_data;
  logic [1:0]            r_resp;
  logic                  ar_hs, r_hs, r_last, r_fetch, r_ok;
  logic [IDX_W-1:0]      r_idx;

  assign ar_hs  = S_AXI_arvalid && S_AXI_arready;
  assign r_hs   = S_AXI_rvalid && S_AXI_rready;
  assign r_last = (r_cnt == r_len);
  assign r_ok   = beat_ok(r_addr, r_burst);
  assign r_idx  = r_addr[IDX_W+2:3];
  // r_addr always points at the next beat to fetch; fetching on the accepting
  // edge keeps beats back-to-back and leaves the output register untouched in stalls.
  assign r_fetch = (r_state == R_FETCH) || (r_state == R_DATA && r_hs && !r_last);

  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_FETCH;
      R_FETCH: r_next = R_DATA;
      R_DATA:  if (r_hs && r_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_arready = 1'b0;
    S_AXI_rvalid  = 1'b0;
    S_AXI_rlast   = 1'b0;
    case (r_state)
      R_IDLE: S_AXI_arready = !reset;
      R_DATA: begin
        S_AXI_rvalid = 1'b1;
        S_AXI_rlast  = r_last;
      end
      default: ;
    endcase
  end

  assign S_AXI_rid   = r_id;
  assign S_AXI_rdata = r_data;
  assign S_AXI_rresp = r_resp;
  assign dbg_r_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        r_id    <= S_AXI_arid;
        r_addr  <= S_AXI_araddr;
        r_len   <= S_AXI_arlen;
        r_size  <= S_AXI_arsize;
        r_burst <= S_AXI_arburst;
        r_cnt   <= '0;
      end
      if (r_fetch) begin
        r_addr <= next_addr(r_addr, r_size, r_burst);
        r_data <= r_ok ? mem[r_idx] : 64'h0;
        r_resp <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_hs && !r_last) r_cnt <= r_cnt + 8'd1;
    end
  end

  logic unused_sideband;
  assign unused_sideband = ^{S_AXI_awlock, S_AXI_awcache, S_AXI_awprot, S_AXI_awqos,
                             S_AXI_arlock, S_AXI_arcache, S_AXI_arprot, S_AXI_arqos};

endmodule

// File: tb/tb_axi4_sram_responder.sv
// Self-checking bench for axi4_sram_responder: drives AXI bursts, predicts
// responses from a byte-accurate memory model and scoreboards the B and R channels.
module tb_axi4_sram_responder;

  localparam int DEPTH = 4096;
  localparam logic [31:0] MEM_TOP = 32'(DEPTH * 8);

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        awvalid, awready, awlock;
  logic [4:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache, awqos;
  logic        wvalid, wready, wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid, bready;
  logic [4:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready, arlock;
  logic [4:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic [3:0]  arcache, arqos;
  logic        rvalid, rready, rlast;
  logic [4:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic [1:0]  dbg_w_state, dbg_r_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] model [int];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [71:0] r_exp_q [$];
  logic [6:0]  b_exp_q [$];
  bit          rr_toggle = 1'b0;

  axi4_sram_responder dut (
    .clk(clk), .reset(reset),
    .S_AXI_awvalid(awvalid), .S_AXI_awready(awready), .S_AXI_awid(awid),
    .S_AXI_awaddr(awaddr), .S_AXI_awlen(awlen), .S_AXI_awsize(awsize),
    .S_AXI_awburst(awburst), .S_AXI_awlock(awlock), .S_AXI_awcache(awcache),
    .S_AXI_awprot(awprot), .S_AXI_awqos(awqos),
    .S_AXI_wvalid(wvalid), .S_AXI_wready(wready), .S_AXI_wdata(wdata),
    .S_AXI_wstrb(wstrb), .S_AXI_wlast(wlast),
    .S_AXI_bvalid(bvalid), .S_AXI_bready(bready), .S_AXI_bid(bid), .S_AXI_bresp(bresp),
    .S_AXI_arvalid(arvalid), .S_AXI_arready(arready), .S_AXI_arid(arid),
    .S_AXI_araddr(araddr), .S_AXI_arlen(arlen), .S_AXI_arsize(arsize),
    .S_AXI_arburst(arburst), .S_AXI_arlock(arlock), .S_AXI_arcache(arcache),
    .S_AXI_arprot(arprot), .S_AXI_arqos(arqos),
    .S_AXI_rvalid(rvalid), .S_AXI_rready(rready), .S_AXI_rid(rid),
    .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rlast(rlast),
    .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [31:0] a);
    int k;
    k = int'(a[14:3]);
    return model.exists(k) ? model[k] : 64'bx;
  endfunction

  // rready is either held high or toggled every cycle
  initial begin
    rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rready = rr_toggle ? ~rready : 1'b1;
    end
  end

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!reset && bvalid) begin
      if (b_exp_q.size() == 0) check("b_unexpected", bvalid, 1'b0);
      else begin
        check("b_resp", {bid, bresp}, b_exp_q[0]);
        if (bready) void'(b_exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && rvalid) begin
      if (r_exp_q.size() == 0) check("r_unexpected", rvalid, 1'b0);
      else begin
        check("r_beat", {rlast, rresp, rid, rdata}, r_exp_q[0]);
        if (rready) void'(r_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr_burst(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats);
    logic [31:0] a;
    logic        err;
    logic [63:0] cur;
    int          k, n, d;
    a   = addr;
    err = (nbeats < int'(len) + 1);
    for (int i = 0; i < nbeats; i++) begin
      if (i > int'(len) || a >= MEM_TOP || burst > 2'd1) err = 1'b1;
      else begin
        k   = int'(a[14:3]);
        cur = model.exists(k) ? model[k] : 64'bx;
        for (int b = 0; b < 8; b++) if (ws[i][b]) cur[b*8 +: 8] = wd[i][b*8 +: 8];
        model[k] = cur;
      end
      if (burst != 2'd0) a = a + 32'd8;
    end
    b_exp_q.push_back({id, err ? 2'b10 : 2'b00});

    @(posedge clk); #1;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    check("aw_accept", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (i > 0) begin
        d = $urandom_range(0, 1);
        repeat (d) begin wvalid = 1'b0; @(posedge clk); #1; end
      end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
      @(negedge clk);
      if (i == 0) check("aw_to_wready", wready, 1'b1);
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      check("w_accept", wready, 1'b1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    check("w_to_bvalid", bvalid, 1'b1);
    @(posedge clk); #1;
    d = $urandom_range(0, 2);
    repeat (d) begin @(posedge clk); #1; end
    bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(bvalid && bready) && n < 50) begin @(negedge clk); n++; end
    check("b_accept", bvalid && bready, 1'b1);
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("b_to_awready", awready, 1'b1);
  endtask

  task automatic rd_burst(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
    logic [31:0] a;
    logic        ok, last;
    logic [1:0]  resp;
    logic [63:0] data;
    int          n;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      ok   = (a < MEM_TOP) && (burst <= 2'd1);
      last = (i == int'(len));
      resp = ok ? 2'b00 : 2'b10;
      data = ok ? model_rd(a) : 64'h0;
      r_exp_q.push_back({last, resp, id, data});
      if (burst != 2'd0) a = a + 32'd8;
    end

    @(posedge clk); #1;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check("ar_accept", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("ar_to_fetch_rvalid", rvalid, 1'b0);
    @(negedge clk);
    check("ar_to_rvalid", rvalid, 1'b1);
    n = 1;
    while (!(rvalid && rready && rlast) && n < 300) begin @(negedge clk); n++; end
    check("r_last_seen", rvalid && rready && rlast, 1'b1);
    if (!rr_toggle) check("r_back_to_back", n, int'(len) + 1);
    @(posedge clk);
    @(negedge clk);
    check("r_to_arready", arready, 1'b1);
    check("r_drained", r_exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, hs;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    awlock = 0; awcache = 0; awprot = 0; awqos = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    arlock = 0; arcache = 0; arprot = 0; arqos = 0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid_rlast", {rvalid, rlast}, 2'b00);
    check("rst_b_payload", {bid, bresp}, 7'd0);
    check("rst_r_payload", {rid, rresp, rdata}, 71'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_awready", awready, 1'b1);
    check("post_rst_arready", arready, 1'b1);

    // single beat
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    wr_burst(5'd5, 32'h10, 8'd0, 2'd1, 1);
    rd_burst(5'd3, 32'h10, 8'd0, 2'd1);

    // INCR burst, read back under rready toggling
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; end
    wr_burst(5'd1, 32'h100, 8'd3, 2'd1, 4);
    rr_toggle = 1'b1;
    rd_burst(5'd2, 32'h100, 8'd3, 2'd1);
    rr_toggle = 1'b0;
    repeat (2) @(posedge clk);

    // partial strobe
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    wr_burst(5'd2, 32'h200, 8'd0, 2'd1, 1);
    wd[0] = 64'h0000_0000_1234_5678; ws[0] = 8'h0F;
    wr_burst(5'd2, 32'h200, 8'd0, 2'd1, 1);
    rd_burst(5'd4, 32'h200, 8'd0, 2'd1);

    // out of range: word 0 must not be touched through index aliasing
    wd[0] = 64'hDEAD_BEEF_CAFE_F00D; ws[0] = 8'hFF;
    wr_burst(5'd0, 32'h0, 8'd0, 2'd1, 1);
    wd[0] = 64'h5555; wd[1] = 64'h6666; ws[0] = 8'hFF; ws[1] = 8'hFF;
    wr_burst(5'd6, MEM_TOP, 8'd1, 2'd1, 2);
    rd_burst(5'd7, MEM_TOP, 8'd1, 2'd1);
    rd_burst(5'd7, 32'h0, 8'd0, 2'd1);

    // WRAP: SLVERR everywhere, no SRAM access
    wd[0] = 64'h7777; wd[1] = 64'h8888;
    wr_burst(5'd7, 32'h10, 8'd1, 2'd2, 2);
    rd_burst(5'd8, 32'h10, 8'd1, 2'd2);
    rd_burst(5'd8, 32'h10, 8'd0, 2'd1);

    // early wlast
    wd[0] = 64'h3001; wd[1] = 64'h3002;
    wr_burst(5'd9, 32'h300, 8'd3, 2'd1, 2);
    rd_burst(5'd9, 32'h300, 8'd1, 2'd1);

    // FIXED write concurrent with an INCR read elsewhere
    for (int i = 0; i < 3; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    fork
      wr_burst(5'd4, 32'h40, 8'd2, 2'd0, 3);
      rd_burst(5'd6, 32'h100, 8'd3, 2'd1);
    join
    rd_burst(5'd10, 32'h40, 8'd0, 2'd1);

    // reset in the middle of a four-beat read
    for (int i = 0; i < 4; i++)
      r_exp_q.push_back({(i == 3), 2'b00, 5'd11, model_rd(32'h100 + 32'(i * 8))});
    @(posedge clk); #1;
    arvalid = 1'b1; arid = 5'd11; araddr = 32'h100; arlen = 8'd3; arsize = 3'd3; arburst = 2'd1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    check("rst_ar_accept", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    hs = 0; n = 0;
    while (hs < 2 && n < 50) begin
      @(negedge clk);
      n++;
      if (rvalid && rready) hs++;
    end
    check("rst_two_beats", hs, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_rvalid", rvalid, 1'b0);
    check("rst_mid_arready", arready, 1'b0);
    r_exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_arready_back", arready, 1'b1);
    check("rst_mid_no_beat", rvalid, 1'b0);
    rd_burst(5'd12, 32'h100, 8'd0, 2'd1);

    repeat (5) @(posedge clk);
    check("final_r_queue", r_exp_q.size(), 0);
    check("final_b_queue", b_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_sram_responder.md
# axi4_sram_responder

AXI4 slave that terminates a 64-bit memory-mapped AXI4 master port, such as the core's memory or MMIO port, and backs it with on-chip dual-port SRAM. Its purposes are:
- a boot/scratch memory;
- a simulation stand-in for the DDR path.

Independent read and write engines each handle one burst at a time, with full valid/ready backpressure on all five channels. It sits in the top-level block design between the core port and the address-decode interconnect.

## Interface
- ADDR_WIDTH, 32: width of awaddr/araddr.
- DEPTH_WORDS, 4096: number of 64-bit SRAM words; power of two.
- ID_WIDTH, 5: AXI ID width.
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- S_AXI_awvalid / S_AXI_awready  input / output  1  write address handshake.
- S_AXI_awid, awlen, awsize, awburst  input  ID_WIDTH, 8, 3, 2  write burst descriptor.
- S_AXI_awaddr  input  ADDR_WIDTH  byte address of first beat.
- S_AXI_wvalid / S_AXI_wready  input / output  1  write data handshake.
- S_AXI_wdata, wstrb, wlast  input  64, 8, 1  write beat.
- S_AXI_bvalid / S_AXI_bready  output / input  1  write response handshake.
- S_AXI_bid, bresp  output  ID_WIDTH, 2  response ID (echo of awid) and status.
- S_AXI_arvalid / S_AXI_arready  input / output  1  read address handshake.
- S_AXI_arid, arlen, arsize, arburst  input  ID_WIDTH, 8, 3, 2  read burst descriptor.
- S_AXI_araddr  input  ADDR_WIDTH  byte address of first beat.
- S_AXI_rvalid / S_AXI_rready  output / input  1  read data handshake.
- S_AXI_rid, rdata, rresp, rlast  output  ID_WIDTH, 64, 2, 1  read beat.
- S_AXI_{aw,ar}{lock,cache,prot,qos}  input  1/4/3/4  accepted, ignored.

## Operation
**Addressing**
- Word index is addr[log2(DEPTH_WORDS)+2:3].
- A beat is out of range when addr ≥ DEPTH_WORDS*8.
- The next beat address is addr + (1<<size) for INCR and addr for FIXED.
- WRAP is unsupported: every beat gets SLVERR and no SRAM access occurs, but all handshakes complete normally.
- The 4 KB boundary is not checked.

**Write FSM: W_IDLE → W_DATA → W_RESP**
- W_IDLE: awready=1. On the AW handshake, latch id, addr, len, size and burst, clear the beat counter, go to W_DATA.
- W_DATA: wready=1. Each W handshake writes the strobed bytes of wdata to the SRAM word, then advances the address and counter.
- Beats beyond len+1 are not written and set an error flag.
- Out-of-range beats are not written and set the error flag.
- wlast terminates the burst and moves to W_RESP.
- wlast arriving before beat len+1 sets the error flag.
- W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if the error flag is set, else 2'b00. Hold until bready, then return to W_IDLE.

**Read FSM: R_IDLE → R_FETCH → R_DATA**
- R_IDLE: arready=1. On the AR handshake, latch the descriptor and go to R_FETCH.
- R_FETCH: SRAM read of the first beat; go to R_DATA.
- R_DATA: rvalid=1, rdata=SRAM output register (0 for an out-of-range or WRAP beat), rresp per beat (SLVERR for out-of-range/WRAP), rid=latched id, rlast=(counter==len).
- On a non-last R handshake, issue the next beat's read the same cycle, so beats are back-to-back.
- While rvalid && !rready, the output register and all r* signals hold stable.
- The last handshake returns the FSM to R_IDLE.

**Shared memory behaviour**
- Read and write engines run concurrently.
- A same-cycle read and write to the same word returns the old data.
- SRAM contents are not reset.

## Timing
**Reset values**
- In reset all FSMs return to idle.
- awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0.
- awready and arready rise the first cycle after reset deasserts.
- Reset mid-burst abandons the burst immediately; no b or r beat is emitted for it.

**Latency**
- AW handshake at cycle t → wready=1 at t+1.
- Last W handshake at t → bvalid at t+1.
- B handshake at t → awready at t+1.
- AR handshake at t → rvalid at t+2. With rready held high, subsequent beats follow at one per cycle.
- Last R handshake at t → arready at t+1.

**Handshake rules**
- Any output asserted as valid stays asserted, with stable payload, until its handshake completes.

## Test plan
- **Single beat:** write awid=5, addr 0x10, len 0, data 0x1122334455667788, strb 0xFF → bid=5, bresp=0. Read arid=3, addr 0x10, len 0 → rid=3, rdata=0x1122334455667788, rlast=1, rresp=0.
- **INCR burst with backpressure:** write len 3 at 0x100 with data 0xA0..0xA3. Read it back while rready toggles every cycle → exactly four beats 0xA0..0xA3 in order, rlast only on the 4th, payload stable during stalls.
- **Partial strobe:** word preloaded with 0xFFFFFFFFFFFFFFFF; write 0x0000000012345678 with strb 0x0F → readback 0xFFFFFFFF12345678.
- **Errors:**
  - Write at DEPTH_WORDS*8, len 1 → bresp=2'b10, no SRAM change.
  - Read at the same address, len 1 → two beats with rresp=2'b10 and rdata=0.
  - WRAP burst → SLVERR on all beats.
  - Write with wlast on beat 2 of len 3 → SLVERR.
- **FIXED burst and concurrency:** FIXED write len 2 to 0x40 with 1, 2, 3 → readback 3. Simultaneously run an INCR read elsewhere → both complete with correct data and no stalls.
- **Reset mid-burst:** assert reset after 2 of 4 read beats → rvalid=0 the next cycle, arready=1 the cycle after release, and a new len-0 read returns the expected data.
